// File: rtl/ex_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ex_pkg
// Description : Shared definitions for the execute-stage controller.
//               Provides ALU op encodings, control-word bit indices and the
//               controller state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package ex_pkg;

    // ALU operation field, control word bits [3:2]
    localparam logic [1:0] ALU_ADD = 2'b01;
    localparam logic [1:0] ALU_SUB = 2'b10;

    // Control word single-bit fields
    localparam int EX_JSEL = 1;  // 0: imm-relative jump, 1: register jump
    localparam int EX_BIMM = 0;  // 0: B operand from R2, 1: from immediate

    // Controller states
    typedef enum logic [1:0] {
        RUN    = 2'd0,
        BUBBLE = 2'd1,
        HOLD   = 2'd2
    } ex_state_t;

endpackage : ex_pkg
`default_nettype wire

// File: rtl/ex_fwd_unit.sv
`default_nettype none
// ============================================================================
// Module      : ex_fwd_unit
// Description : Combinational operand forwarding for one EX source operand.
//               Selects the MEM result, else the WB data, else the value held
//               in the ID/EX register. Register 0 is never forwarded.
// Ports       : i_rs            - source register address of the EX operand
//               i_reg_val       - operand value held in ID/EX
//               i_mem_*         - MEM stage write enable / rd / result
//               i_wb_*          - WB stage write enable / rd / data
//               o_fwd_val       - forwarded operand
// Revision    : 1.0 - initial release
// ============================================================================
module ex_fwd_unit #(
    parameter int REG_W = 32,
    parameter int RA_W  = 5
) (
    input  logic [RA_W-1:0]  i_rs,
    input  logic [REG_W-1:0] i_reg_val,
    input  logic             i_mem_wen,
    input  logic [RA_W-1:0]  i_mem_rd,
    input  logic [REG_W-1:0] i_mem_result,
    input  logic             i_wb_wen,
    input  logic [RA_W-1:0]  i_wb_rd,
    input  logic [REG_W-1:0] i_wb_data,
    output logic [REG_W-1:0] o_fwd_val
);

    logic w_mem_hit;
    logic w_wb_hit;

    assign w_mem_hit = i_mem_wen && (i_mem_rd != '0) && (i_mem_rd == i_rs);
    assign w_wb_hit  = i_wb_wen  && (i_wb_rd  != '0) && (i_wb_rd  == i_rs);

    // MEM holds the younger result, so it wins over WB
    always_comb begin
        o_fwd_val = i_reg_val;
        if (w_mem_hit) begin
            o_fwd_val = i_mem_result;
        end else if (w_wb_hit) begin
            o_fwd_val = i_wb_data;
        end
    end

endmodule : ex_fwd_unit
`default_nettype wire

// File: rtl/ex_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : ex_ctrl
// Description : Execute-stage controller. Owns the ID/EX pipeline register,
//               forwards MEM/WB results into the exec operands, inserts
//               load-use bubbles, redirects fetch on jumps, holds on
//               downstream back-pressure and counts stall/flush events.
// Ports       : clk, rst                 - clock, synchronous active-high reset
//               id_*                     - decode-side instruction fields
//               mem_*, wb_*              - MEM/WB write-back info for forwarding
//               mem_stall                - downstream back-pressure
//               ex_pc_jmp                - jump target computed by exec
//               ex_*                     - EX-stage control and operands
//               id_stall, flush          - IF/ID hold / kill
//               redirect, redirect_pc    - fetch redirect request and target
//               stall_cnt, flush_cnt     - saturating event counters
// Revision    : 1.0 - initial release
// ============================================================================
module ex_ctrl
    import ex_pkg::*;
#(
    parameter int REG_W = 32,
    parameter int RA_W  = 5,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_valid,
    input  logic             id_wen,
    input  logic             id_load,
    input  logic             id_jmp,
    input  logic [3:0]       id_ex,
    input  logic [RA_W-1:0]  id_rs1,
    input  logic [RA_W-1:0]  id_rs2,
    input  logic [RA_W-1:0]  id_rd,
    input  logic [REG_W-1:0] id_r1,
    input  logic [REG_W-1:0] id_r2,
    input  logic [REG_W-1:0] id_imm,
    input  logic [REG_W-1:0] id_pc_n,
    input  logic             mem_wen,
    input  logic             wb_wen,
    input  logic [RA_W-1:0]  mem_rd,
    input  logic [RA_W-1:0]  wb_rd,
    input  logic [REG_W-1:0] mem_result,
    input  logic [REG_W-1:0] wb_data,
    input  logic             mem_stall,
    input  logic [REG_W-1:0] ex_pc_jmp,
    output logic             ex_valid,
    output logic             ex_wen,
    output logic             ex_load,
    output logic [3:0]       ex_op,
    output logic [RA_W-1:0]  ex_rd,
    output logic [REG_W-1:0] ex_r1,
    output logic [REG_W-1:0] ex_r2,
    output logic [REG_W-1:0] ex_imm,
    output logic [REG_W-1:0] ex_pc_n,
    output logic             id_stall,
    output logic             flush,
    output logic             redirect,
    output logic [REG_W-1:0] redirect_pc,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam logic [CNT_W-1:0] c_cnt_one = {{(CNT_W-1){1'b0}}, 1'b1};

    ex_state_t        r_state;
    ex_state_t        w_state_nxt;

    // ID/EX pipeline register
    logic             r_ex_valid;
    logic             r_ex_wen;
    logic             r_ex_load;
    logic             r_ex_jmp;
    logic [3:0]       r_ex_op;
    logic [RA_W-1:0]  r_ex_rd;
    logic [RA_W-1:0]  r_ex_rs1;
    logic [RA_W-1:0]  r_ex_rs2;
    logic [REG_W-1:0] r_ex_r1;
    logic [REG_W-1:0] r_ex_r2;
    logic [REG_W-1:0] r_ex_imm;
    logic [REG_W-1:0] r_ex_pc_n;

    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_flush_cnt;

    logic             w_jump;
    logic             w_load_use;
    logic             w_luse_take;
    logic             w_bubble;
    logic             w_id_stall;
    logic             w_flush;
    logic [REG_W-1:0] w_cap_r1;
    logic [REG_W-1:0] w_cap_r2;

    // A held jump must not redirect until back-pressure releases
    assign w_jump = r_ex_valid && r_ex_jmp && !mem_stall;

    // rs2 only matters when the B operand really comes from the register file
    assign w_load_use = r_ex_valid && r_ex_load && (r_ex_rd != '0) && id_valid &&
                        ((r_ex_rd == id_rs1) ||
                         ((r_ex_rd == id_rs2) && !id_ex[EX_BIMM]));

    // WB is writing the register file this cycle; bypass it into the capture
    assign w_cap_r1 = (wb_wen && (wb_rd != '0) && (wb_rd == id_rs1)) ? wb_data : id_r1;
    assign w_cap_r2 = (wb_wen && (wb_rd != '0) && (wb_rd == id_rs2)) ? wb_data : id_r2;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic. The release cycle out of HOLD re-checks load-use,
    // since the dependent instruction may still be waiting in ID.
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            RUN: begin
                if (mem_stall) begin
                    w_state_nxt = HOLD;
                end else if (w_luse_take) begin
                    w_state_nxt = BUBBLE;
                end
            end
            BUBBLE: begin
                w_state_nxt = RUN;
            end
            HOLD: begin
                if (mem_stall) begin
                    w_state_nxt = HOLD;
                end else if (w_luse_take) begin
                    w_state_nxt = BUBBLE;
                end else begin
                    w_state_nxt = RUN;
                end
            end
            default: begin
                w_state_nxt = RUN;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Control outputs: jump outranks load-use, back-pressure outranks both
    // ------------------------------------------------------------------
    always_comb begin
        w_flush     = w_jump;
        w_luse_take = w_load_use && !w_jump && !mem_stall;
        w_id_stall  = mem_stall || w_luse_take;
        w_bubble    = w_jump || w_luse_take;
    end

    // ------------------------------------------------------------------
    // ID/EX register: hold, bubble, or capture
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst || (!mem_stall && w_bubble)) begin
            r_ex_valid <= 1'b0;
            r_ex_wen   <= 1'b0;
            r_ex_load  <= 1'b0;
            r_ex_jmp   <= 1'b0;
            r_ex_op    <= '0;
            r_ex_rd    <= '0;
            r_ex_rs1   <= '0;
            r_ex_rs2   <= '0;
            r_ex_r1    <= '0;
            r_ex_r2    <= '0;
            r_ex_imm   <= '0;
            r_ex_pc_n  <= '0;
        end else if (!mem_stall) begin
            r_ex_valid <= id_valid;
            r_ex_wen   <= id_wen;
            r_ex_load  <= id_load;
            r_ex_jmp   <= id_jmp;
            r_ex_op    <= id_ex;
            r_ex_rd    <= id_rd;
            r_ex_rs1   <= id_rs1;
            r_ex_rs2   <= id_rs2;
            r_ex_r1    <= w_cap_r1;
            r_ex_r2    <= w_cap_r2;
            r_ex_imm   <= id_imm;
            r_ex_pc_n  <= id_pc_n;
        end
    end

    // ------------------------------------------------------------------
    // Saturating event counters
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (w_id_stall && (r_stall_cnt != '1)) begin
                r_stall_cnt <= r_stall_cnt + c_cnt_one;
            end
            if (w_flush && (r_flush_cnt != '1)) begin
                r_flush_cnt <= r_flush_cnt + c_cnt_one;
            end
        end
    end

    // ------------------------------------------------------------------
    // EX operand forwarding
    // ------------------------------------------------------------------
    ex_fwd_unit #(
        .REG_W (REG_W),
        .RA_W  (RA_W)
    ) u_fwd_rs1 (
        .i_rs         (r_ex_rs1),
        .i_reg_val    (r_ex_r1),
        .i_mem_wen    (mem_wen),
        .i_mem_rd     (mem_rd),
        .i_mem_result (mem_result),
        .i_wb_wen     (wb_wen),
        .i_wb_rd      (wb_rd),
        .i_wb_data    (wb_data),
        .o_fwd_val    (ex_r1)
    );

    ex_fwd_unit #(
        .REG_W (REG_W),
        .RA_W  (RA_W)
    ) u_fwd_rs2 (
        .i_rs         (r_ex_rs2),
        .i_reg_val    (r_ex_r2),
        .i_mem_wen    (mem_wen),
        .i_mem_rd     (mem_rd),
        .i_mem_result (mem_result),
        .i_wb_wen     (wb_wen),
        .i_wb_rd      (wb_rd),
        .i_wb_data    (wb_data),
        .o_fwd_val    (ex_r2)
    );

    assign ex_valid    = r_ex_valid;
    assign ex_wen      = r_ex_wen;
    assign ex_load     = r_ex_load;
    assign ex_op       = r_ex_op;
    assign ex_rd       = r_ex_rd;
    assign ex_imm      = r_ex_imm;
    assign ex_pc_n     = r_ex_pc_n;
    assign id_stall    = w_id_stall;
    assign flush       = w_flush;
    assign redirect    = w_flush;
    assign redirect_pc = ex_pc_jmp;
    assign stall_cnt   = r_stall_cnt;
    assign flush_cnt   = r_flush_cnt;

endmodule : ex_ctrl
`default_nettype wire

// File: tb/tb_ex_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_ex_ctrl
// Description : Self-checking bench for ex_ctrl. Expected EX-stage contents
//               are queued when an instruction is driven and compared when
//               it leaves EX; control outputs and counters are checked
//               directly against hand-derived values.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ex_ctrl;
    import ex_pkg::*;

    logic        clk;
    logic        rst;
    logic        id_valid, id_wen, id_load, id_jmp;
    logic [3:0]  id_ex;
    logic [4:0]  id_rs1, id_rs2, id_rd;
    logic [31:0] id_r1, id_r2, id_imm, id_pc_n;
    logic        mem_wen, wb_wen;
    logic [4:0]  mem_rd, wb_rd;
    logic [31:0] mem_result, wb_data;
    logic        mem_stall;
    logic [31:0] ex_pc_jmp;
    logic        ex_valid, ex_wen, ex_load;
    logic [3:0]  ex_op;
    logic [4:0]  ex_rd;
    logic [31:0] ex_r1, ex_r2, ex_imm, ex_pc_n;
    logic        id_stall, flush, redirect;
    logic [31:0] redirect_pc;
    logic [15:0] stall_cnt, flush_cnt;

    ex_ctrl #(.REG_W(32), .RA_W(5), .CNT_W(16)) dut (
        .clk(clk), .rst(rst),
        .id_valid(id_valid), .id_wen(id_wen), .id_load(id_load), .id_jmp(id_jmp),
        .id_ex(id_ex), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
        .id_r1(id_r1), .id_r2(id_r2), .id_imm(id_imm), .id_pc_n(id_pc_n),
        .mem_wen(mem_wen), .wb_wen(wb_wen), .mem_rd(mem_rd), .wb_rd(wb_rd),
        .mem_result(mem_result), .wb_data(wb_data), .mem_stall(mem_stall),
        .ex_pc_jmp(ex_pc_jmp),
        .ex_valid(ex_valid), .ex_wen(ex_wen), .ex_load(ex_load), .ex_op(ex_op),
        .ex_rd(ex_rd), .ex_r1(ex_r1), .ex_r2(ex_r2), .ex_imm(ex_imm),
        .ex_pc_n(ex_pc_n), .id_stall(id_stall), .flush(flush),
        .redirect(redirect), .redirect_pc(redirect_pc),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        wen;
        logic        load;
        logic [3:0]  op;
        logic [4:0]  rd;
        logic [31:0] r1;
        logic [31:0] r2;
        logic [31:0] imm;
        logic [31:0] pc_n;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   n_run  = 0;
    int   n_fail = 0;

    localparam logic [3:0] c_op_add_imm = {ALU_ADD, 1'b0, 1'b1};
    localparam logic [3:0] c_op_add_reg = {ALU_ADD, 1'b0, 1'b0};
    localparam logic [3:0] c_op_jmp_reg = {ALU_ADD, 1'b1, 1'b0};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_id(input logic v, input logic wen, input logic load, input logic jmp,
                            input logic [3:0] ex, input logic [4:0] rs1, input logic [4:0] rs2,
                            input logic [4:0] rd, input logic [31:0] r1, input logic [31:0] r2,
                            input logic [31:0] imm, input logic [31:0] pcn);
        id_valid = v;   id_wen = wen; id_load = load; id_jmp = jmp; id_ex = ex;
        id_rs1   = rs1; id_rs2 = rs2; id_rd   = rd;
        id_r1    = r1;  id_r2  = r2;  id_imm  = imm;  id_pc_n = pcn;
    endtask

    task automatic idle_id();
        drive_id(1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 32'h0);
    endtask

    task automatic idle_fwd();
        mem_wen = 1'b0; mem_rd = 5'd0; mem_result = 32'h0;
        wb_wen  = 1'b0; wb_rd  = 5'd0; wb_data    = 32'h0;
    endtask

    task automatic push_exp(input logic wen, input logic load, input logic [3:0] op,
                            input logic [4:0] rd, input logic [31:0] r1, input logic [31:0] r2,
                            input logic [31:0] imm, input logic [31:0] pcn);
        exp_t x;
        x.wen = wen; x.load = load; x.op = op; x.rd = rd;
        x.r1 = r1; x.r2 = r2; x.imm = imm; x.pc_n = pcn;
        sb.push_back(x);
    endtask

    // An instruction retires from EX in a cycle where it is valid and not held
    always @(negedge clk) begin
        if (!rst && ex_valid && !mem_stall) begin
            if (sb.size() == 0) begin
                check("sb_unexpected_valid", 32'(ex_valid), 32'd0);
            end else begin
                e = sb.pop_front();
                check("sb_wen",  32'(ex_wen),  32'(e.wen));
                check("sb_load", 32'(ex_load), 32'(e.load));
                check("sb_op",   32'(ex_op),   32'(e.op));
                check("sb_rd",   32'(ex_rd),   32'(e.rd));
                check("sb_r1",   ex_r1,        e.r1);
                check("sb_r2",   ex_r2,        e.r2);
                check("sb_imm",  ex_imm,       e.imm);
                check("sb_pc_n", ex_pc_n,      e.pc_n);
            end
        end
    end

    initial begin
        rst = 1'b1; mem_stall = 1'b0; ex_pc_jmp = 32'h0;
        idle_id(); idle_fwd();
        tick(); tick();
        rst = 1'b0;
        #1;
        check("rst_ex_valid",  32'(ex_valid),  32'd0);
        check("rst_stall_cnt", 32'(stall_cnt), 32'd0);
        check("rst_flush_cnt", 32'(flush_cnt), 32'd0);
        check("rst_redirect",  32'(redirect),  32'd0);
        check("rst_flush",     32'(flush),     32'd0);
        check("rst_id_stall",  32'(id_stall),  32'd0);
        check("rst_ex_r1",     ex_r1,          32'h0);
        check("rst_ex_pc_n",   ex_pc_n,        32'h0);

        // ---- load-use: load r5, then add r6 = r5 + r1 ----
        drive_id(1, 1, 1, 0, c_op_add_imm, 5'd2, 5'd0, 5'd5, 32'h10, 32'h0, 32'h4, 32'h8);
        push_exp(1, 1, c_op_add_imm, 5'd5, 32'h10, 32'h0, 32'h4, 32'h8);
        tick();
        drive_id(1, 1, 0, 0, c_op_add_reg, 5'd5, 5'd1, 5'd6, 32'h999, 32'h77, 32'h0, 32'hC);
        #1;
        check("lu_id_stall_on", 32'(id_stall), 32'd1);
        check("lu_flush",       32'(flush),    32'd0);
        tick();
        #1;
        check("lu_bubble_valid", 32'(ex_valid),  32'd0);
        check("lu_id_stall_off", 32'(id_stall),  32'd0);
        check("lu_stall_cnt",    32'(stall_cnt), 32'd1);
        push_exp(1, 0, c_op_add_reg, 5'd6, 32'hAA, 32'h77, 32'h0, 32'hC);
        tick();
        idle_id();
        wb_wen = 1'b1; wb_rd = 5'd5; wb_data = 32'h0000_00AA;
        #1;
        check("lu_add_r1_wb", ex_r1, 32'h0000_00AA);
        check("lu_stall_cnt_hold", 32'(stall_cnt), 32'd1);
        tick();
        idle_fwd();

        // ---- forward priority; rs2 captured through WB bypass ----
        drive_id(1, 1, 0, 0, c_op_add_reg, 5'd3, 5'd4, 5'd7, 32'h33, 32'h44, 32'h0, 32'h10);
        wb_wen = 1'b1; wb_rd = 5'd4; wb_data = 32'h4444;
        push_exp(1, 0, c_op_add_reg, 5'd7, 32'h11, 32'h4444, 32'h0, 32'h10);
        tick();
        idle_id();
        mem_wen = 1'b1; mem_rd = 5'd3; mem_result = 32'h11;
        wb_wen  = 1'b1; wb_rd  = 5'd3; wb_data    = 32'h22;
        #1;
        check("fwd_mem_over_wb", ex_r1, 32'h11);
        @(negedge clk); #1;
        mem_rd = 5'd0; wb_rd = 5'd0;
        #1;
        check("fwd_r0_none", ex_r1, 32'h33);
        mem_wen = 1'b0; wb_rd = 5'd3;
        #1;
        check("fwd_wb_only", ex_r1, 32'h22);
        tick();
        idle_fwd();

        // ---- jump ----
        drive_id(1, 1, 0, 1, c_op_add_reg, 5'd0, 5'd0, 5'd1, 32'h0, 32'h0, 32'hDC, 32'h24);
        push_exp(1, 0, c_op_add_reg, 5'd1, 32'h0, 32'h0, 32'hDC, 32'h24);
        tick();
        drive_id(1, 1, 0, 0, c_op_add_reg, 5'd1, 5'd2, 5'd9, 32'h1, 32'h2, 32'h0, 32'h28);
        ex_pc_jmp = 32'h0000_0100;
        #1;
        check("jmp_redirect",    32'(redirect), 32'd1);
        check("jmp_redirect_pc", redirect_pc,   32'h100);
        check("jmp_flush",       32'(flush),    32'd1);
        check("jmp_no_stall",    32'(id_stall), 32'd0);
        tick();
        idle_id();
        #1;
        check("jmp_next_valid",  32'(ex_valid),  32'd0);
        check("jmp_flush_once",  32'(flush),     32'd0);
        check("jmp_flush_cnt",   32'(flush_cnt), 32'd1);
        tick();

        // ---- jump held by 3 cycles of back-pressure ----
        drive_id(1, 0, 0, 1, c_op_jmp_reg, 5'd2, 5'd0, 5'd0, 32'h200, 32'h0, 32'h0, 32'h40);
        push_exp(0, 0, c_op_jmp_reg, 5'd0, 32'h200, 32'h0, 32'h0, 32'h40);
        tick();
        drive_id(1, 1, 0, 0, c_op_add_reg, 5'd1, 5'd1, 5'd9, 32'h1, 32'h1, 32'h0, 32'h44);
        ex_pc_jmp = 32'h0000_0200;
        mem_stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            check($sformatf("bp_redirect_off%0d", i), 32'(redirect), 32'd0);
            check($sformatf("bp_id_stall%0d", i),     32'(id_stall), 32'd1);
            tick();
        end
        mem_stall = 1'b0;
        #1;
        check("bp_redirect_on", 32'(redirect),  32'd1);
        check("bp_redirect_pc", redirect_pc,    32'h200);
        check("bp_stall_cnt",   32'(stall_cnt), 32'd4);
        tick();
        idle_id();
        #1;
        check("bp_redirect_once", 32'(redirect),  32'd0);
        check("bp_next_valid",    32'(ex_valid),  32'd0);
        check("bp_flush_cnt",     32'(flush_cnt), 32'd2);
        tick();

        // ---- load-use coinciding with back-pressure ----
        drive_id(1, 1, 1, 0, c_op_add_imm, 5'd0, 5'd0, 5'd8, 32'h80, 32'h0, 32'h0, 32'h50);
        push_exp(1, 1, c_op_add_imm, 5'd8, 32'h80, 32'h0, 32'h0, 32'h50);
        tick();
        drive_id(1, 1, 0, 0, c_op_add_reg, 5'd8, 5'd0, 5'd9, 32'h55, 32'h0, 32'h0, 32'h54);
        mem_stall = 1'b1;
        #1;
        check("lus_id_stall_hold", 32'(id_stall), 32'd1);
        tick();
        mem_stall = 1'b0;
        #1;
        check("lus_id_stall_rel", 32'(id_stall),  32'd1);
        check("lus_held_valid",   32'(ex_valid),  32'd1);
        check("lus_stall_cnt",    32'(stall_cnt), 32'd5);
        tick();
        #1;
        check("lus_bubble_valid", 32'(ex_valid), 32'd0);
        check("lus_id_stall_off", 32'(id_stall), 32'd0);
        push_exp(1, 0, c_op_add_reg, 5'd9, 32'h55, 32'h0, 32'h0, 32'h54);
        tick();
        idle_id();
        #1;
        check("lus_stall_cnt_end", 32'(stall_cnt), 32'd6);
        tick();

        // ---- reset while a jump is held ----
        drive_id(1, 0, 0, 1, c_op_add_reg, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 32'h60);
        tick();
        idle_id();
        mem_stall = 1'b1;
        ex_pc_jmp = 32'h0000_0300;
        #1;
        check("rh_redirect_held", 32'(redirect), 32'd0);
        tick();
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        mem_stall = 1'b0;
        #1;
        check("rh_ex_valid",  32'(ex_valid),  32'd0);
        check("rh_stall_cnt", 32'(stall_cnt), 32'd0);
        check("rh_flush_cnt", 32'(flush_cnt), 32'd0);
        check("rh_redirect",  32'(redirect),  32'd0);
        check("sb_drained",   32'(sb.size()), 32'd0);
        tick();

        // ---- stall counter saturation ----
        mem_stall = 1'b1;
        repeat (65534) tick();
        check("sat_below", 32'(stall_cnt), 32'h0000_FFFE);
        tick();
        check("sat_reach", 32'(stall_cnt), 32'h0000_FFFF);
        repeat (70000 - 65535) tick();
        check("sat_hold", 32'(stall_cnt), 32'h0000_FFFF);
        mem_stall = 1'b0;
        tick();
        check("sat_no_wrap",   32'(stall_cnt), 32'h0000_FFFF);
        check("sat_flush_cnt", 32'(flush_cnt), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule : tb_ex_ctrl
`default_nettype wire

// File: doc/ex_ctrl.md
# ex_ctrl

Execute-stage controller sitting between decode and the `exec` datapath. It owns the ID/EX pipeline register and forwards MEM/WB results into the exec operands. It also inserts load-use bubbles, redirects fetch on resolved jumps, and holds the stage on downstream back-pressure. Two saturating event counters expose stall and flush activity to the debug bus.

## Interface
- `REG_W`, 32, datapath width
- `RA_W`, 5, register-address width
- `CNT_W`, 16, width of each event counter
- `clk`  in  1  single clock
- `rst`  in  1  reset, synchronous, active-high
- `id_valid, id_wen, id_load, id_jmp`  in  1 each  decode-side valid, writes rd, is load, is jump
- `id_ex`  in  4  exec control word: [3:2] ALU op (01 add, 10 sub), [1] jump select (0 imm-relative, 1 register), [0] B-source select (0 R2, 1 imm)
- `id_rs1, id_rs2, id_rd`  in  RA_W  source and destination register addresses
- `id_r1, id_r2, id_imm, id_pc_n`  in  REG_W  register-file reads, sign-extended immediate, next PC
- `mem_wen, wb_wen`  in  1  MEM/WB stage write enables
- `mem_rd, wb_rd`  in  RA_W  MEM/WB destination registers
- `mem_result, wb_data`  in  REG_W  MEM/WB result values
- `mem_stall`  in  1  downstream back-pressure
- `ex_pc_jmp`  in  REG_W  jump target returned by `exec`
- `ex_valid, ex_wen, ex_load`  out  1  EX-stage valid and control
- `ex_op`  out  4  control word to `exec` (EX)
- `ex_rd`  out  RA_W  EX destination register
- `ex_r1, ex_r2, ex_imm, ex_pc_n`  out  REG_W  forwarded operands to `exec`
- `id_stall`  out  1  hold IF/ID this cycle
- `flush`  out  1  kill IF/ID contents this cycle
- `redirect`  out  1  load fetch PC from `redirect_pc`
- `redirect_pc`  out  REG_W  equals `ex_pc_jmp`
- `stall_cnt, flush_cnt`  out  CNT_W  event counters

## Operation
- FSM states: RUN, BUBBLE, HOLD.
- **RUN → HOLD** when `mem_stall`. Stay in HOLD while `mem_stall`. Return to RUN when `mem_stall` drops.
- **RUN → BUBBLE** on load-use. The condition is `ex_valid & ex_load & ex_rd!=0 & id_valid`, and `ex_rd` equals `id_rs1`, or equals `id_rs2` with `id_ex[0]==0`. BUBBLE always returns to RUN the next cycle.
- **Jump:** `redirect = flush = ex_valid & ex_jmp & !mem_stall`.
  - Jump priority is above load-use: no BUBBLE entry in that cycle.
  - On the next edge, ID/EX loads a bubble.
- **ID/EX update, highest priority first:**
  1. `mem_stall`: hold.
  2. jump: bubble (`ex_valid=0`).
  3. load-use: bubble.
  4. Otherwise capture `id_*`, with `ex_valid=id_valid`.
- **Bubble contents:** `ex_valid=0`, `ex_wen=0`, `ex_load=0`, `ex_jmp=0`. Data fields are don't-care; drive 0.
- **`id_stall`:** asserted during load-use (RUN detecting it) and whenever `mem_stall`.
- **Capture-time forwarding:** if `wb_wen & wb_rd!=0 & wb_rd==id_rsN`, the captured operand is `wb_data`.
- **EX-output forwarding** (combinational, per operand N):
  - MEM match (`mem_wen & mem_rd!=0 & mem_rd==ex_rsN`) selects `mem_result`.
  - Otherwise a WB match selects `wb_data`.
  - Otherwise the registered value.
  - MEM has priority over WB. Register 0 is never forwarded.
- **Counters:**
  - `stall_cnt` increments each cycle `id_stall=1`.
  - `flush_cnt` increments each cycle `flush=1`.
  - Both saturate at all-ones, never wrap.

## Timing
- Latency: decode fields appear on `ex_*` one cycle after capture.
- `redirect`, `flush`, `id_stall` are combinational within the cycle.
- Reset values:
  - state RUN; `ex_valid`, `ex_wen`, `ex_load`, `ex_jmp` = 0; all `ex_*` data = 0; counters = 0.
  - Hence `redirect`, `flush`, `id_stall` (absent `mem_stall`) read 0 in the first cycle after reset.
- Reset mid-HOLD or mid-BUBBLE discards the held instruction. No redirect is emitted.
- Load-use and `mem_stall` in the same cycle: go to HOLD. Re-evaluate load-use after release.
- Jump and `mem_stall` in the same cycle: suppress redirect. The held jump redirects in the first cycle `mem_stall=0`.

## Structure
- Shared package `ex_pkg`:
  - ALU op constants `ALU_ADD=2'b01`, `ALU_SUB=2'b10`.
  - Bit indices `EX_JSEL=1`, `EX_BIMM=0`.
  - State enum {RUN, BUBBLE, HOLD}.
- Sub-module `ex_fwd_unit`: forwarding compare/mux for one operand, instantiated twice (rs1, rs2). It is purely combinational.
- FSM, ID/EX register, and counters live in `ex_ctrl`.

## Test plan
- **Reset:** `rst` high 2 cycles mid-HOLD → next cycle `ex_valid=0`, `stall_cnt=0`, `redirect=0`.
- **Load-use:**
  - Stimulus: load r5, then add r6=r5+r1.
  - Required: one BUBBLE, `id_stall=1` for exactly 1 cycle, `stall_cnt=1`.
  - The add then sees `ex_r1=wb_data=0x0000_00AA`.
- **Forward priority:**
  - Stimulus: `mem_rd=wb_rd=3`, `mem_result=0x11`, `wb_data=0x22`, EX reads r3.
  - Required: `ex_r1=0x11`. With `mem_rd=0` as well, `ex_r1` stays the registered value.
- **Jump:**
  - Stimulus: jump with `ex_pc_jmp=0x0000_0100`.
  - Required: `redirect=1`, `redirect_pc=0x100`, `flush=1` for one cycle; next cycle `ex_valid=0`; `flush_cnt=1`.
- **Jump under back-pressure:**
  - Stimulus: `mem_stall` 3 cycles during a jump.
  - Required: `redirect=0` for 3 cycles, then 1 for one cycle; `stall_cnt=3`.
- **Saturation:**
  - Stimulus: `mem_stall` held 70000 cycles.
  - Required: `stall_cnt=0xFFFF`, no wrap.
